matmul_agu: RTL and testbench



---
 rtl/matmul_agu_pkg.sv | 13 +
 rtl/loop_counter.sv | 47 ++++
 rtl/matmul_agu.sv | 173 +++++++++++++++++
 tb/tb_matmul_agu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_agu_pkg.sv
// Shared types and constants for the matrix-multiply address-generation unit.
package matmul_agu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ROWMAJOR   = 1'b0;
  localparam logic MODE_TRANSPOSED = 1'b1;

endpackage

// File: rtl/loop_counter.sv
// One loop level of the walk: counts 0..limit-1, flags the last value and the
// wrap back to zero.
module loop_counter #(
  parameter int unsigned DIM_W = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             load_i,
  input  logic [DIM_W-1:0] limit_i,
  input  logic             en_i,
  output logic             is_last_o,
  output logic             wrap_c_o
);

  logic [DIM_W-1:0] cnt_q, cnt_d;
  logic [DIM_W-1:0] limit_q, limit_d;
  logic             is_last_q, is_last_d;

  // is_last is precomputed for the next value so it leaves as a flop
  always_comb begin
    cnt_d   = cnt_q;
    limit_d = limit_q;
    if (load_i) begin
      limit_d = limit_i;
      cnt_d   = '0;
    end else if (en_i) begin
      cnt_d = is_last_q ? '0 : cnt_q + DIM_W'(1);
    end
    is_last_d = (cnt_d == limit_d - DIM_W'(1));
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q     <= '0;
      limit_q   <= '0;
      is_last_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      limit_q   <= limit_d;
      is_last_q <= is_last_d;
    end
  end

  assign is_last_o = is_last_q;
  assign wrap_c_o  = en_i & is_last_q;

endmodule

// File: rtl/matmul_agu.sv
// Address sequencer for C = A*B: walks i, j, k (k innermost) and emits one
// A/B/C address beat per handshake, using only running adds.
module matmul_agu
  import matmul_agu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIM_W = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             mode_i,
  input  logic [DIM_W-1:0] dim_m_i,
  input  logic [DIM_W-1:0] dim_k_i,
  input  logic [DIM_W-1:0] dim_n_i,
  input  logic [WIDTH-1:0] base_a_i,
  input  logic [WIDTH-1:0] base_b_i,
  input  logic [WIDTH-1:0] base_c_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] addr_a_o,
  output logic [WIDTH-1:0] addr_b_o,
  output logic [WIDTH-1:0] addr_c_o,
  output logic             first_k_o,
  output logic             last_k_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  state_e state_q, state_d;

  logic launch_c, zero_dim_c, hs_c;
  logic k_wrap_c, j_wrap_c, i_wrap_c;
  logic k_last;
  logic [1:0] unused_last;

  logic             mode_q, mode_d;
  logic [WIDTH-1:0] step_k_q, step_k_d, step_n_q, step_n_d;
  logic [WIDTH-1:0] base_b_q, base_b_d;
  logic [WIDTH-1:0] row_a_q, row_a_d, col_b_q, col_b_d;
  logic [WIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
  logic             valid_q, valid_d, first_k_q, first_k_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

  assign launch_c   = (state_q == IDLE) && start_i;
  assign zero_dim_c = (dim_m_i == '0) || (dim_k_i == '0) || (dim_n_i == '0);
  assign hs_c       = (state_q == RUN) && valid_q && out_ready_i && !abort_i;

  loop_counter #(.DIM_W(DIM_W)) u_k (
    .Clk(Clk), .Rst_n(Rst_n), .load_i(launch_c), .limit_i(dim_k_i),
    .en_i(hs_c), .is_last_o(k_last), .wrap_c_o(k_wrap_c)
  );
  loop_counter #(.DIM_W(DIM_W)) u_j (
    .Clk(Clk), .Rst_n(Rst_n), .load_i(launch_c), .limit_i(dim_n_i),
    .en_i(k_wrap_c), .is_last_o(unused_last[0]), .wrap_c_o(j_wrap_c)
  );
  loop_counter #(.DIM_W(DIM_W)) u_i (
    .Clk(Clk), .Rst_n(Rst_n), .load_i(launch_c), .limit_i(dim_m_i),
    .en_i(j_wrap_c), .is_last_o(unused_last[1]), .wrap_c_o(i_wrap_c)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // i wrapping means the handshake was on the final beat of the walk
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = zero_dim_c ? DONE : RUN;
      RUN: begin
        if (abort_i)       state_d = IDLE;
        else if (i_wrap_c) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // row_a tracks the A row start, col_b the B address at k=0 for column j
  always_comb begin
    mode_d    = mode_q;
    step_k_d  = step_k_q;
    step_n_d  = step_n_q;
    base_b_d  = base_b_q;
    row_a_d   = row_a_q;
    col_b_d   = col_b_q;
    addr_a_d  = addr_a_q;
    addr_b_d  = addr_b_q;
    addr_c_d  = addr_c_q;
    first_k_d = first_k_q;
    if (launch_c) begin
      mode_d    = mode_i;
      step_k_d  = WIDTH'(dim_k_i);
      step_n_d  = WIDTH'(dim_n_i);
      base_b_d  = base_b_i;
      row_a_d   = base_a_i;
      col_b_d   = base_b_i;
      addr_a_d  = base_a_i;
      addr_b_d  = base_b_i;
      addr_c_d  = base_c_i;
      first_k_d = 1'b1;
    end else if (hs_c) begin
      first_k_d = k_wrap_c;
      if (!k_wrap_c) begin
        addr_a_d = addr_a_q + WIDTH'(1);
        addr_b_d = addr_b_q + ((mode_q == MODE_TRANSPOSED) ? WIDTH'(1) : step_n_q);
      end else begin
        addr_c_d = addr_c_q + WIDTH'(1);
        if (j_wrap_c) begin
          row_a_d = row_a_q + step_k_q;
          col_b_d = base_b_q;
        end else begin
          col_b_d = col_b_q + ((mode_q == MODE_TRANSPOSED) ? step_k_q : WIDTH'(1));
        end
        addr_a_d = row_a_d;
        addr_b_d = col_b_d;
      end
    end
    valid_d = (state_d == RUN);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    err_d   = launch_c && zero_dim_c;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mode_q    <= MODE_ROWMAJOR;
      step_k_q  <= '0;
      step_n_q  <= '0;
      base_b_q  <= '0;
      row_a_q   <= '0;
      col_b_q   <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      addr_c_q  <= '0;
      first_k_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      step_k_q  <= step_k_d;
      step_n_q  <= step_n_d;
      base_b_q  <= base_b_d;
      row_a_q   <= row_a_d;
      col_b_q   <= col_b_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      addr_c_q  <= addr_c_d;
      first_k_q <= first_k_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign out_valid_o = valid_q;
  assign addr_a_o    = addr_a_q;
  assign addr_b_o    = addr_b_q;
  assign addr_c_o    = addr_c_q;
  assign first_k_o   = first_k_q;
  assign last_k_o    = k_last;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_matmul_agu.sv
// Scoreboard bench for matmul_agu: expected beats are generated from the
// matrix index formulas and compared in order at each handshake.
`timescale 1ns/1ps
module tb_matmul_agu;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIM_W = 8;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic       fk;
    logic       lk;
  } beat_t;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic             start = 1'b0, abort = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic [DIM_W-1:0] dim_m = '0, dim_k = '0, dim_n = '0;
  logic [WIDTH-1:0] base_a = '0, base_b = '0, base_c = '0;
  logic             out_valid_o, first_k_o, last_k_o, busy_o, done_o, err_o;
  logic [WIDTH-1:0] addr_a_o, addr_b_o, addr_c_o;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    n_chk = 0;
  int    n_fail = 0;

  matmul_agu #(.WIDTH(WIDTH), .DIM_W(DIM_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .start_i(start), .abort_i(abort), .mode_i(mode),
    .dim_m_i(dim_m), .dim_k_i(dim_k), .dim_n_i(dim_n),
    .base_a_i(base_a), .base_b_i(base_b), .base_c_i(base_c),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready),
    .addr_a_o(addr_a_o), .addr_b_o(addr_b_o), .addr_c_o(addr_c_o),
    .first_k_o(first_k_o), .last_k_o(last_k_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic beat_t sample();
    return beat_t'({addr_a_o, addr_b_o, addr_c_o, first_k_o, last_k_o});
  endfunction

  function automatic beat_t obs_at(input int idx);
    if (idx < obs_q.size()) return obs_q[idx];
    return '0;
  endfunction

  task automatic build(input int m, input int k, input int n, input logic [7:0] ba,
                       input logic [7:0] bb, input logic [7:0] bc, input logic md);
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++)
        for (int kk = 0; kk < k; kk++) begin
          beat_t e;
          e.a  = 8'(int'(ba) + i * k + kk);
          e.b  = md ? 8'(int'(bb) + j * k + kk) : 8'(int'(bb) + kk * n + j);
          e.c  = 8'(int'(bc) + i * n + j);
          e.fk = (kk == 0);
          e.lk = (kk == k - 1);
          exp_q.push_back(e);
        end
  endtask

  task automatic walk(input int m, input int k, input int n, input logic [7:0] ba,
                      input logic [7:0] bb, input logic [7:0] bc, input logic md,
                      input int rdy_pct, input int abort_at, input int poke_at);
    int    total, acc, last_hs, done_cyc, budget;
    bit    stalled, do_abort;
    beat_t held, cur, e;
    total = m * n * k;
    acc = 0; last_hs = 0; done_cyc = 0; stalled = 0; do_abort = 0;
    held = '0; cur = '0;
    exp_q.delete();
    obs_q.delete();
    build(m, k, n, ba, bb, bc, md);
    budget = total * 8 + 10;
    mode = md; dim_m = DIM_W'(m); dim_k = DIM_W'(k); dim_n = DIM_W'(n);
    base_a = ba; base_b = bb; base_c = bc; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    base_a = ~ba; base_b = ~bb; base_c = ~bc; mode = ~md;
    dim_m = 8'd7; dim_k = 8'd5; dim_n = 8'd3;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      out_ready = ($urandom_range(99) < 32'(rdy_pct));
      start = 1'b0;
      abort = 1'b0;
      if (acc == poke_at) start = 1'b1;
      if (acc == abort_at) begin
        abort = 1'b1; out_ready = 1'b1; do_abort = 1'b1;
      end
      @(negedge Clk);
      if (cyc == 1) begin
        check("first_valid", 32'(out_valid_o), 32'(total > 0));
        check("busy_on", 32'(busy_o), 32'd1);
      end
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      if (out_valid_o) begin
        cur = sample();
        if (stalled) check("stall_hold", 32'(cur), 32'(held));
        if (out_ready && !do_abort) begin
          if (exp_q.size() == 0) check("beat_count", 32'(acc + 1), 32'(total));
          else begin
            e = exp_q.pop_front();
            check("beat", 32'(cur), 32'(e));
          end
          obs_q.push_back(cur);
          acc++;
          last_hs = cyc;
        end
        stalled = !out_ready;
        held = cur;
      end else begin
        stalled = 1'b0;
      end
      if (do_abort) break;
      @(posedge Clk); #1;
    end
    start = 1'b0;
    if (do_abort) begin
      check("abort_valid_pre", 32'(out_valid_o), 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("abort_beat", 32'(cur), 32'(e));
      @(posedge Clk); #1;
      abort = 1'b0; out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge Clk);
        check("abort_valid", 32'(out_valid_o), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        @(posedge Clk); #1;
      end
      return;
    end
    check("done_seen", 32'(done_cyc != 0), 32'd1);
    check("done_err", 32'(err_o), 32'(total == 0));
    check("done_valid", 32'(out_valid_o), 32'd0);
    check("done_busy", 32'(busy_o), 32'd1);
    check("beats", 32'(acc), 32'(total));
    if (total > 0) check("done_lat", 32'(done_cyc), 32'(last_hs + 1));
    if (rdy_pct == 100) check("done_time", 32'(done_cyc), 32'(total + 1));
    @(posedge Clk); #1;
    @(negedge Clk);
    check("idle_busy", 32'(busy_o), 32'd0);
    check("idle_done", 32'(done_o), 32'd0);
    check("idle_err", 32'(err_o), 32'd0);
    check("idle_valid", 32'(out_valid_o), 32'd0);
    @(posedge Clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    beat_t b;
    #12;
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_beat", 32'(sample()), 32'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    // row-major B, full throughput
    walk(2, 3, 2, 8'h00, 8'h10, 8'h20, 1'b0, 100, -1, -1);
    b = obs_at(0);  check("m0_beat1", 32'(b), 32'(beat_t'({8'h00, 8'h10, 8'h20, 1'b1, 1'b0})));
    b = obs_at(2);  check("m0_beat3", 32'(b), 32'(beat_t'({8'h02, 8'h14, 8'h20, 1'b0, 1'b1})));
    b = obs_at(11); check("m0_beat12", 32'(b), 32'(beat_t'({8'h05, 8'h15, 8'h23, 1'b0, 1'b1})));

    // transposed B
    walk(2, 3, 2, 8'h00, 8'h10, 8'h20, 1'b1, 100, -1, -1);
    b = obs_at(3);  check("m1_beat4_b", 32'(b.b), 32'h13);
    b = obs_at(11); check("m1_beat12_b", 32'(b.b), 32'h15);

    // random back-pressure
    walk(2, 3, 2, 8'h00, 8'h10, 8'h20, 1'b0, 50, -1, -1);
    walk(3, 2, 4, 8'hF0, 8'h7C, 8'hE9, 1'b1, 50, -1, -1);

    // zero dimension
    walk(2, 0, 2, 8'h00, 8'h10, 8'h20, 1'b0, 100, -1, -1);

    // address wrap, K=1
    walk(1, 1, 4, 8'h00, 8'h00, 8'hFE, 1'b0, 100, -1, -1);
    b = obs_at(2); check("wrap_c3", 32'(b.c), 32'h00);
    b = obs_at(3); check("wrap_c4", 32'(b.c), 32'h01);

    // start during RUN, abort at beat 5, abort on the final beat
    walk(2, 3, 2, 8'h00, 8'h10, 8'h20, 1'b0, 100, -1, 3);
    walk(2, 3, 2, 8'h00, 8'h10, 8'h20, 1'b0, 100, 4, -1);
    walk(1, 1, 1, 8'h40, 8'h50, 8'h60, 1'b0, 100, 0, -1);

    // asynchronous reset mid-beat, then a fresh walk
    mode = 1'b0; dim_m = 8'd2; dim_k = 8'd3; dim_n = 8'd2;
    base_a = 8'h00; base_b = 8'h10; base_c = 8'h20; start = 1'b1; out_ready = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (3) @(negedge Clk);
    check("pre_rst_valid", 32'(out_valid_o), 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_beat", 32'(sample()), 32'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    out_ready = 1'b0;
    @(posedge Clk); #1;
    walk(2, 3, 2, 8'h00, 8'h10, 8'h20, 1'b0, 100, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
